// File: rtl/elevator_request_scheduler.sv
// SCAN-policy request scheduler for a single elevator car: latches hall/car calls,
// steps the car one floor per travel period and times the door dwell.
module elevator_request_scheduler #(
  parameter int NUM_FLOORS    = 5,
  parameter int FLOOR_W       = 4,
  parameter int TRAVEL_CYCLES = 50000000,
  parameter int DOOR_CYCLES   = 100000000,
  parameter int TIMER_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FLOOR_W-1:0]    hall_floor,
  input  logic                  hall_up,
  input  logic                  hall_down,
  input  logic [NUM_FLOORS-1:0] car_req,
  input  logic                  update,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic [1:0]            direction,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MOVING = 2'd1;
  localparam logic [1:0] ST_DOOR   = 2'd2;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  localparam logic [FLOOR_W-1:0]    TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W-1:0]    GROUND      = {FLOOR_W{1'b0}};
  localparam logic [TIMER_W-1:0]    TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES);
  localparam logic [TIMER_W-1:0]    DOOR_LOAD   = TIMER_W'(DOOR_CYCLES);
  localparam logic [TIMER_W-1:0]    TIMER_ONE   = TIMER_W'(1);
  localparam logic [NUM_FLOORS-1:0] NO_FLOORS   = {NUM_FLOORS{1'b0}};

  function automatic logic [NUM_FLOORS-1:0] floorBit(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = {NUM_FLOORS{1'b0}};
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (f == FLOOR_W'(i));
    return m;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] aboveMask(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = {NUM_FLOORS{1'b0}};
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (FLOOR_W'(i) > f);
    return m;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] belowMask(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = {NUM_FLOORS{1'b0}};
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (FLOOR_W'(i) < f);
    return m;
  endfunction

  logic [1:0]            state_r;
  logic [FLOOR_W-1:0]    curFloor_r;
  logic [1:0]            dir_r;
  logic [1:0]            lastDir_r;
  logic                  doorOpen_r;
  logic [TIMER_W-1:0]    timer_r;
  logic [NUM_FLOORS-1:0] carPend_r;
  logic [NUM_FLOORS-1:0] upPend_r;
  logic [NUM_FLOORS-1:0] downPend_r;

  logic [NUM_FLOORS-1:0] pendAll_s;
  logic [NUM_FLOORS-1:0] curBit_s;
  logic [NUM_FLOORS-1:0] hallBit_s;
  logic [NUM_FLOORS-1:0] carSet_s;
  logic [NUM_FLOORS-1:0] upSet_s;
  logic [NUM_FLOORS-1:0] downSet_s;
  logic [NUM_FLOORS-1:0] carClr_s;
  logic [NUM_FLOORS-1:0] upClr_s;
  logic [NUM_FLOORS-1:0] downClr_s;
  logic                  absorb_s;
  logic                  hereReq_s;
  logic                  aheadUpCur_s;
  logic                  aheadDownCur_s;
  logic [1:0]            oppDir_s;
  logic [FLOOR_W-1:0]    nextFloor_s;
  logic [NUM_FLOORS-1:0] nextBit_s;
  logic                  movingUp_s;
  logic                  aheadNext_s;
  logic                  dirHallNext_s;
  logic                  anyHallNext_s;
  logic                  atEnd_s;
  logic                  stop_s;
  logic                  arrive_s;

  assign pendAll_s      = carPend_r | upPend_r | downPend_r;
  assign curBit_s       = floorBit(curFloor_r);
  assign hallBit_s      = floorBit(hall_floor);
  assign hereReq_s      = |(pendAll_s & curBit_s);
  assign aheadUpCur_s   = |(pendAll_s & aboveMask(curFloor_r));
  assign aheadDownCur_s = |(pendAll_s & belowMask(curFloor_r));
  assign oppDir_s       = (lastDir_r == DIR_UP) ? DIR_DOWN : DIR_UP;

  // Qualify incoming calls; while the door is open, calls for this floor are absorbed.
  always_comb begin
    carSet_s  = NO_FLOORS;
    upSet_s   = NO_FLOORS;
    downSet_s = NO_FLOORS;
    absorb_s  = 1'b0;
    if (update) begin
      carSet_s  = car_req;
      upSet_s   = (hall_up && (hall_floor < TOP_FLOOR)) ? hallBit_s : NO_FLOORS;
      downSet_s = (hall_down && (hall_floor != GROUND) && (hall_floor <= TOP_FLOOR))
                  ? hallBit_s : NO_FLOORS;
    end else begin
      carSet_s  = NO_FLOORS;
    end
    if (state_r == ST_DOOR) begin
      absorb_s  = |((carSet_s | upSet_s | downSet_s) & curBit_s);
      carSet_s  = carSet_s & ~curBit_s;
      upSet_s   = upSet_s & ~curBit_s;
      downSet_s = downSet_s & ~curBit_s;
    end else begin
      absorb_s  = 1'b0;
    end
  end

  // Floor the car reaches when the current travel period expires (clamped to the shaft).
  always_comb begin
    nextFloor_s = curFloor_r;
    if ((dir_r == DIR_UP) && (curFloor_r != TOP_FLOOR)) begin
      nextFloor_s = curFloor_r + FLOOR_W'(1);
    end else if ((dir_r == DIR_DOWN) && (curFloor_r != GROUND)) begin
      nextFloor_s = curFloor_r - FLOOR_W'(1);
    end else begin
      nextFloor_s = curFloor_r;
    end
  end

  assign nextBit_s     = floorBit(nextFloor_s);
  assign movingUp_s    = (dir_r == DIR_UP);
  assign aheadNext_s   = movingUp_s ? |(pendAll_s & aboveMask(nextFloor_s))
                                    : |(pendAll_s & belowMask(nextFloor_s));
  assign dirHallNext_s = movingUp_s ? |(upPend_r & nextBit_s) : |(downPend_r & nextBit_s);
  assign anyHallNext_s = |((upPend_r | downPend_r) & nextBit_s);
  assign atEnd_s       = movingUp_s ? (nextFloor_s == TOP_FLOOR) : (nextFloor_s == GROUND);
  assign stop_s        = (|(carPend_r & nextBit_s)) || dirHallNext_s
                         || (!aheadNext_s && anyHallNext_s) || atEnd_s;
  assign arrive_s      = (state_r == ST_MOVING) && (timer_r <= TIMER_ONE);

  // Served bits: a reversing stop also serves the opposite-direction hall call.
  always_comb begin
    carClr_s  = NO_FLOORS;
    upClr_s   = NO_FLOORS;
    downClr_s = NO_FLOORS;
    if ((state_r == ST_IDLE) && hereReq_s) begin
      carClr_s  = curBit_s;
      upClr_s   = curBit_s;
      downClr_s = curBit_s;
    end else if (arrive_s && stop_s) begin
      carClr_s = nextBit_s;
      if (movingUp_s) begin
        upClr_s   = nextBit_s;
        downClr_s = aheadNext_s ? NO_FLOORS : nextBit_s;
      end else begin
        downClr_s = nextBit_s;
        upClr_s   = aheadNext_s ? NO_FLOORS : nextBit_s;
      end
    end else begin
      carClr_s = NO_FLOORS;
    end
  end

  // Pending request registers; a clear only coincides with a set on a served floor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carPend_r  <= {NUM_FLOORS{1'b0}};
      upPend_r   <= {NUM_FLOORS{1'b0}};
      downPend_r <= {NUM_FLOORS{1'b0}};
    end else begin
      carPend_r  <= (carPend_r | carSet_s) & ~carClr_s;
      upPend_r   <= (upPend_r | upSet_s) & ~upClr_s;
      downPend_r <= (downPend_r | downSet_s) & ~downClr_s;
    end
  end

  // Motion/door sequencer with the shared travel/dwell timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      curFloor_r <= {FLOOR_W{1'b0}};
      dir_r      <= DIR_IDLE;
      lastDir_r  <= DIR_UP;
      doorOpen_r <= 1'b0;
      timer_r    <= {TIMER_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (hereReq_s) begin
            state_r    <= ST_DOOR;
            doorOpen_r <= 1'b1;
            timer_r    <= DOOR_LOAD;
          end else if ((lastDir_r == DIR_UP) ? aheadUpCur_s : aheadDownCur_s) begin
            state_r <= ST_MOVING;
            dir_r   <= lastDir_r;
            timer_r <= TRAVEL_LOAD;
          end else if ((lastDir_r == DIR_UP) ? aheadDownCur_s : aheadUpCur_s) begin
            state_r   <= ST_MOVING;
            dir_r     <= oppDir_s;
            lastDir_r <= oppDir_s;
            timer_r   <= TRAVEL_LOAD;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_MOVING: begin
          if (arrive_s) begin
            curFloor_r <= nextFloor_s;
            if (stop_s) begin
              state_r    <= ST_DOOR;
              doorOpen_r <= 1'b1;
              timer_r    <= DOOR_LOAD;
            end else begin
              timer_r <= TRAVEL_LOAD;
            end
          end else begin
            timer_r <= timer_r - TIMER_ONE;
          end
        end
        ST_DOOR: begin
          if (absorb_s) begin
            timer_r <= DOOR_LOAD;
          end else if (timer_r <= TIMER_ONE) begin
            state_r    <= ST_IDLE;
            doorOpen_r <= 1'b0;
            dir_r      <= DIR_IDLE;
            timer_r    <= {TIMER_W{1'b0}};
          end else begin
            timer_r <= timer_r - TIMER_ONE;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          dir_r      <= DIR_IDLE;
          doorOpen_r <= 1'b0;
          timer_r    <= {TIMER_W{1'b0}};
        end
      endcase
    end
  end

  assign cur_floor = curFloor_r;
  assign direction = dir_r;
  assign door_open = doorOpen_r;
  assign pending   = pendAll_s;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed bench for elevator_request_scheduler with short travel/door timing.
module tb_elevator_request_scheduler;

  logic       clk;
  logic       rst_n;
  logic [3:0] hall_floor;
  logic       hall_up;
  logic       hall_down;
  logic [4:0] car_req;
  logic       update;
  logic [3:0] cur_floor;
  logic [1:0] direction;
  logic       door_open;
  logic [4:0] pending;

  int checkCnt = 0;
  int passCnt  = 0;

  elevator_request_scheduler #(
    .NUM_FLOORS(5), .FLOOR_W(4), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3), .TIMER_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hall_floor(hall_floor), .hall_up(hall_up),
    .hall_down(hall_down), .car_req(car_req), .update(update),
    .cur_floor(cur_floor), .direction(direction), .door_open(door_open),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    if (obs === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [4:0] car, input logic [3:0] hf, input logic hu, input logic hd);
    car_req = car; hall_floor = hf; hall_up = hu; hall_down = hd; update = 1'b1;
    tick(1);
    car_req = 5'b00000; hall_floor = 4'd0; hall_up = 1'b0; hall_down = 1'b0; update = 1'b0;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    rst_n = 1'b0; hall_floor = 4'd0; hall_up = 1'b0; hall_down = 1'b0;
    car_req = 5'b00000; update = 1'b0;
    tick(1);
    checkEq("rst_floor", 32'(cur_floor), 32'd0);
    checkEq("rst_dir",   32'(direction), 32'd0);
    checkEq("rst_door",  32'(door_open), 32'd0);
    checkEq("rst_pend",  32'(pending),   32'd0);
    rst_n = 1'b1;
    tick(1);

    // Single car call to floor 3
    pulse(5'b01000, 4'd0, 1'b0, 1'b0);
    checkEq("t1_latch",  32'(pending),   32'(5'b01000));
    checkEq("t1_dir0",   32'(direction), 32'd0);
    tick(1);
    checkEq("t1_dirup",  32'(direction), 32'd1);
    checkEq("t1_fl0",    32'(cur_floor), 32'd0);
    tick(3);
    checkEq("t1_fl0b",   32'(cur_floor), 32'd0);
    tick(1);
    checkEq("t1_fl1",    32'(cur_floor), 32'd1);
    tick(4);
    checkEq("t1_fl2",    32'(cur_floor), 32'd2);
    tick(4);
    checkEq("t1_fl3",    32'(cur_floor), 32'd3);
    checkEq("t1_door",   32'(door_open), 32'd1);
    checkEq("t1_pend",   32'(pending),   32'd0);
    checkEq("t1_dirhld", 32'(direction), 32'd1);
    tick(2);
    checkEq("t1_door2",  32'(door_open), 32'd1);
    tick(1);
    checkEq("t1_close",  32'(door_open), 32'd0);
    checkEq("t1_idle",   32'(direction), 32'd0);

    // Car to 4 with an up call at 2 picked up on the way
    resetDut();
    pulse(5'b10000, 4'd0, 1'b0, 1'b0);
    tick(2);
    pulse(5'b00000, 4'd2, 1'b1, 1'b0);
    checkEq("t2_pend",   32'(pending),   32'(5'b10100));
    tick(6);
    checkEq("t2_fl2",    32'(cur_floor), 32'd2);
    checkEq("t2_door",   32'(door_open), 32'd1);
    checkEq("t2_pend2",  32'(pending),   32'(5'b10000));
    tick(3);
    checkEq("t2_close",  32'(door_open), 32'd0);
    checkEq("t2_idle",   32'(direction), 32'd0);
    tick(1);
    checkEq("t2_resume", 32'(direction), 32'd1);
    tick(8);
    checkEq("t2_fl4",    32'(cur_floor), 32'd4);
    checkEq("t2_door4",  32'(door_open), 32'd1);
    checkEq("t2_pend4",  32'(pending),   32'd0);

    // Car to 4 with a down call at 2: pass it, then serve it after reversing
    resetDut();
    pulse(5'b10000, 4'd0, 1'b0, 1'b0);
    tick(2);
    pulse(5'b00000, 4'd2, 1'b0, 1'b1);
    checkEq("t3_pend",   32'(pending),   32'(5'b10100));
    tick(6);
    checkEq("t3_fl2",    32'(cur_floor), 32'd2);
    checkEq("t3_pass",   32'(door_open), 32'd0);
    checkEq("t3_dirup",  32'(direction), 32'd1);
    tick(8);
    checkEq("t3_fl4",    32'(cur_floor), 32'd4);
    checkEq("t3_door4",  32'(door_open), 32'd1);
    checkEq("t3_pend4",  32'(pending),   32'(5'b00100));
    tick(4);
    checkEq("t3_dirdn",  32'(direction), 32'd2);
    checkEq("t3_door4c", 32'(door_open), 32'd0);
    tick(8);
    checkEq("t3_fl2b",   32'(cur_floor), 32'd2);
    checkEq("t3_door2",  32'(door_open), 32'd1);
    checkEq("t3_pend2",  32'(pending),   32'd0);
    checkEq("t3_dirhld", 32'(direction), 32'd2);

    // Illegal hall calls are ignored
    resetDut();
    pulse(5'b00000, 4'd7, 1'b1, 1'b1);
    checkEq("t4_oob",    32'(pending),   32'd0);
    pulse(5'b00000, 4'd4, 1'b1, 1'b0);
    checkEq("t4_topup",  32'(pending),   32'd0);
    pulse(5'b00000, 4'd0, 1'b0, 1'b1);
    checkEq("t4_gnddn",  32'(pending),   32'd0);
    tick(1);
    checkEq("t4_dir",    32'(direction), 32'd0);
    checkEq("t4_door",   32'(door_open), 32'd0);

    // Same-floor call during the last door cycle reopens the dwell
    resetDut();
    pulse(5'b01000, 4'd0, 1'b0, 1'b0);
    tick(13);
    checkEq("t5_door",   32'(door_open), 32'd1);
    tick(2);
    pulse(5'b01000, 4'd0, 1'b0, 1'b0);
    checkEq("t5_held",   32'(door_open), 32'd1);
    checkEq("t5_pend",   32'(pending),   32'd0);
    tick(2);
    checkEq("t5_held2",  32'(door_open), 32'd1);
    tick(1);
    checkEq("t5_close",  32'(door_open), 32'd0);
    checkEq("t5_idle",   32'(direction), 32'd0);

    // Asynchronous reset between floors 2 and 3
    resetDut();
    pulse(5'b10000, 4'd0, 1'b0, 1'b0);
    tick(10);
    checkEq("t6_fl2",    32'(cur_floor), 32'd2);
    checkEq("t6_mov",    32'(direction), 32'd1);
    rst_n = 1'b0;
    #1;
    checkEq("t6_rfloor", 32'(cur_floor), 32'd0);
    checkEq("t6_rdir",   32'(direction), 32'd0);
    checkEq("t6_rdoor",  32'(door_open), 32'd0);
    checkEq("t6_rpend",  32'(pending),   32'd0);
    #2;
    rst_n = 1'b1;
    tick(3);
    checkEq("t6_idle",   32'(direction), 32'd0);
    checkEq("t6_floor",  32'(cur_floor), 32'd0);
    checkEq("t6_pend",   32'(pending),   32'd0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/elevator_request_scheduler.md
Name: elevator_request_scheduler

Overview:
- Request-scheduling controller for the single-car elevator.
- Latches hall calls (floor index plus up/down) and car-panel calls (one bit per floor) into pending registers.
- Sequences car motion floor by floor using a SCAN policy: keep the current direction while requests lie ahead, otherwise reverse, otherwise idle.
- Drives current floor, direction and door state to the display/indicator logic; travel and door dwell are timed by internal counters.

Parameters:
- NUM_FLOORS, 5, number of floors; floors are indexed 0..NUM_FLOORS-1.
- FLOOR_W, 4, width of floor-index ports.
- TRAVEL_CYCLES, 50000000, clock cycles to move one floor (1 s at 50 MHz).
- DOOR_CYCLES, 100000000, clock cycles the door stays open.
- TIMER_W, 32, width of the shared travel/door timer.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- hall_floor  in  FLOOR_W  floor index of the hall call.
- hall_up  in  1  hall call going up, qualified by update.
- hall_down  in  1  hall call going down, qualified by update.
- car_req  in  NUM_FLOORS  car-panel buttons, multi-hot, qualified by update.
- update  in  1  one-cycle strobe; latches hall and car inputs.
- cur_floor  out  FLOOR_W  current car floor.
- direction  out  2  00 idle, 01 up, 10 down.
- door_open  out  1  high while the door is open.
- pending  out  NUM_FLOORS  OR of car, up and down pending bits, per floor.

Behaviour:
- Reset (async assert, sync release): cur_floor=0, direction=00, door_open=0, all pending registers 0, state IDLE, last_dir=up, timer=0.
- Latch: on the update edge, car_pend |= car_req; up_pend[hall_floor] |= hall_up; down_pend[hall_floor] |= down. The following are silently ignored:
  - hall_floor >= NUM_FLOORS;
  - hall_up at the top floor;
  - hall_down at floor 0.
- Set and clear of the same bit in the same cycle: clear wins only when that floor is being served in that cycle (arrival stop or door open at that floor). Otherwise set wins.
- "Ahead" means any pending bit at a floor strictly beyond cur_floor in the given direction.
- IDLE state (direction=00, door_open=0), evaluated every cycle:
  - Any pending bit at cur_floor: clear car/up/down at cur_floor, go to DOOR, load DOOR_CYCLES.
  - Else requests ahead in last_dir: go to MOVING in last_dir.
  - Else requests in the opposite direction: go to MOVING in the opposite direction and set last_dir to it.
  - Else stay in IDLE.
  - On entering MOVING: direction updates in the same edge and TRAVEL_CYCLES is loaded. Latency from the update edge to direction!=00 is exactly one cycle.
- MOVING state:
  - Timer decrements each cycle.
  - When timer==1: cur_floor steps by ±1 on that edge, then the new floor f is checked. Stop if:
    - car_pend[f] is set, or
    - the hall bit matching the travel direction at f is set, or
    - there are no requests ahead and any hall bit at f is set.
  - On a stop: clear car_pend[f] and the served hall bit. If reversing, the served hall bit is the opposite-direction bit. Go to DOOR and load DOOR_CYCLES.
  - On no stop: reload TRAVEL_CYCLES and continue.
  - cur_floor never leaves 0..NUM_FLOORS-1. Reaching an end floor forces a stop.
- DOOR state:
  - door_open=1; direction holds the last travel value (00 if entered from IDLE).
  - Timer decrements; on expiry go to IDLE (door_open=0).
  - A car or hall request for cur_floor arriving during DOOR is absorbed (not latched) and reloads DOOR_CYCLES.
- pending is combinational from the pending registers.
- Reset asserted mid-travel or with the door open returns all outputs to reset values immediately.

Test Plan:
(Bench uses TRAVEL_CYCLES=4, DOOR_CYCLES=3.)
- Reset, then update with car_req=5'b01000 at floor 0 -> next edge direction=01. cur_floor reaches 1, 2, 3 at 4-cycle intervals. At floor 3 door_open=1 for 3 cycles, pending=0. Then direction=00.
- Car at 0, car_req floor 4 latched; during the first travel leg, hall_floor=2 with hall_up -> stops at 2 (door 3 cycles), continues to 4.
- Same as above but hall_down at floor 2 -> passes floor 2, stops at 4, reverses, stops at 2. pending[2] clears on that arrival.
- Illegal calls: hall_floor=7, hall_up at 4, hall_down at 0 -> pending stays 5'b00000, direction stays 00.
- Door open at floor 3 with 1 cycle left; update car_req=5'b01000 -> door_open stays 1 for 3 more cycles, pending[3]=0.
- Moving between floors 2 and 3 with pending bits set; pulse rst_n low -> same cycle: cur_floor=0, direction=00, door_open=0, pending=0. After release, stays idle.
